// File: rtl/region_attr_pkg.sv
// Shared types for the region attribute unit: attribute bits, config field codes, rule record.
package region_attr_pkg;

  localparam int unsigned MaxAddrWidth = 64;

  // Bit 0 cacheable, bit 1 executable, bit 2 non-idempotent, bit 3 capability-tag enable.
  typedef struct packed {
    logic cap_tag;
    logic non_idem;
    logic exec;
    logic cacheable;
  } attr_t;

  typedef enum logic [1:0] {
    FIELD_BASE   = 2'd0,
    FIELD_LENGTH = 2'd1,
    FIELD_ATTR   = 2'd2,
    FIELD_RSVD   = 2'd3
  } cfg_field_e;

  // Stored at full width; units built with a narrower AddrWidth keep the upper bits at zero.
  typedef struct packed {
    logic [MaxAddrWidth-1:0] base;
    logic [MaxAddrWidth-1:0] length;
    attr_t                   attr;
    logic                    lock;
  } rule_t;

endpackage

// File: rtl/region_attr_match.sv
// Single-rule compare: hit when enabled, at or above base, and less than length beyond it.
module region_attr_match #(
  parameter int unsigned AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [AddrWidth-1:0] base_i,
  input  logic [AddrWidth-1:0] length_i,
  output logic                 match_o
);

  logic [AddrWidth-1:0] offset;

  // The base test gates the offset compare, so regions never wrap past the top of the space.
  assign offset  = addr_i - base_i;
  assign match_o = (length_i != '0) && (addr_i >= base_i) && (offset < length_i);

endmodule

// File: rtl/region_attr_unit.sv
// Programmable physical-memory attribute unit: config port for base/length/attr/lock rules
// plus a two-stage pipelined lookup returning the attributes of the lowest matching rule.
module region_attr_unit
  import region_attr_pkg::*;
#(
  parameter int unsigned                          NrRules     = 4,
  parameter int unsigned                          AddrWidth   = 64,
  parameter logic [NrRules-1:0][AddrWidth-1:0]    RstBase     = '0,
  parameter logic [NrRules-1:0][AddrWidth-1:0]    RstLength   = '0,
  parameter logic [NrRules-1:0][3:0]              RstAttr     = '0,
  parameter logic [3:0]                           DefaultAttr = 4'b0000,
  localparam int unsigned IdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [IdxWidth-1:0]  cfg_idx_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_rvalid_o,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 lkp_valid_i,
  output logic                 lkp_ready_o,
  input  logic [AddrWidth-1:0] lkp_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [IdxWidth-1:0]  rsp_idx_o,
  output logic [3:0]           rsp_attr_o
);

  rule_t rules_q [NrRules];

  // ---------------- configuration port ----------------
  cfg_field_e           field;
  logic                 idx_ok;
  logic                 cfg_bad;
  logic                 cfg_err_d;
  logic                 cfg_wr_en;
  rule_t                sel_rule;
  logic [AddrWidth-1:0] cfg_rdata_d;

  assign field     = cfg_field_e'(cfg_field_i);
  assign idx_ok    = (32'(cfg_idx_i) < NrRules);
  assign sel_rule  = idx_ok ? rules_q[cfg_idx_i] : '0;
  assign cfg_bad   = !idx_ok || (field == FIELD_RSVD);
  assign cfg_err_d = cfg_bad || (cfg_we_i && sel_rule.lock);
  assign cfg_wr_en = cfg_req_i && cfg_we_i && !cfg_err_d;

  always_comb begin
    cfg_rdata_d = '0;
    if (!cfg_we_i && !cfg_bad) begin
      case (field)
        FIELD_BASE:   cfg_rdata_d = sel_rule.base[AddrWidth-1:0];
        FIELD_LENGTH: cfg_rdata_d = sel_rule.length[AddrWidth-1:0];
        FIELD_ATTR:   cfg_rdata_d = AddrWidth'({sel_rule.lock, sel_rule.attr});
        default:      cfg_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_rvalid_o <= 1'b0;
      cfg_err_o    <= 1'b0;
      cfg_rdata_o  <= '0;
    end else begin
      cfg_rvalid_o <= cfg_req_i;
      cfg_err_o    <= cfg_req_i && cfg_err_d;
      cfg_rdata_o  <= cfg_req_i ? cfg_rdata_d : '0;
    end
  end

  // Lock is sticky: once set, cfg_wr_en stays low for that rule until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrRules; i++) begin
        rules_q[i].base   <= MaxAddrWidth'(RstBase[i]);
        rules_q[i].length <= MaxAddrWidth'(RstLength[i]);
        rules_q[i].attr   <= attr_t'(RstAttr[i]);
        rules_q[i].lock   <= 1'b0;
      end
    end else if (cfg_wr_en) begin
      case (field)
        FIELD_BASE:   rules_q[cfg_idx_i].base   <= MaxAddrWidth'(cfg_wdata_i);
        FIELD_LENGTH: rules_q[cfg_idx_i].length <= MaxAddrWidth'(cfg_wdata_i);
        FIELD_ATTR: begin
          rules_q[cfg_idx_i].attr <= attr_t'(cfg_wdata_i[3:0]);
          rules_q[cfg_idx_i].lock <= cfg_wdata_i[4];
        end
        default: ;
      endcase
    end
  end

  // ---------------- lookup pipeline ----------------
  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on the same-side valid, and a held response stays stable until taken.
  logic [NrRules-1:0]  match_vec;
  logic                s1_valid_q;
  logic [NrRules-1:0]  s1_match_q;
  logic                s1_en;
  logic                s2_en;
  logic                lkp_accept;
  logic                enc_hit;
  logic [IdxWidth-1:0] enc_idx;
  logic [3:0]          enc_attr;

  for (genvar g = 0; g < NrRules; g++) begin : g_match
    region_attr_match #(
      .AddrWidth(AddrWidth)
    ) u_match (
      .addr_i  (lkp_addr_i),
      .base_i  (rules_q[g].base[AddrWidth-1:0]),
      .length_i(rules_q[g].length[AddrWidth-1:0]),
      .match_o (match_vec[g])
    );
  end

  assign s2_en       = !rsp_valid_o || rsp_ready_i;
  assign s1_en       = !s1_valid_q || s2_en;
  assign lkp_ready_o = s1_en;
  assign lkp_accept  = lkp_valid_i && lkp_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_match_q <= '0;
    end else if (s1_en) begin
      s1_valid_q <= lkp_accept;
      s1_match_q <= lkp_accept ? match_vec : '0;
    end
  end

  // Attributes are read here, at S2 load, not at compare time.
  always_comb begin
    enc_hit  = 1'b0;
    enc_idx  = '0;
    enc_attr = DefaultAttr;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (s1_match_q[i]) begin
        enc_hit  = 1'b1;
        enc_idx  = IdxWidth'(i);
        enc_attr = rules_q[i].attr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_hit_o   <= 1'b0;
      rsp_idx_o   <= '0;
      rsp_attr_o  <= '0;
    end else if (s2_en) begin
      rsp_valid_o <= s1_valid_q;
      rsp_hit_o   <= enc_hit;
      rsp_idx_o   <= enc_idx;
      rsp_attr_o  <= enc_attr;
    end
  end

endmodule

// File: tb/tb_region_attr_unit.sv
// Bench for region_attr_unit: directed tables, hand-timed corner sequences, random lookups vs model.
module tb_region_attr_unit;
  import region_attr_pkg::*;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam logic [N-1:0][AW-1:0] RST_BASE   = {64'h0, 64'h0, 64'h0, 64'h8000_0000};
  localparam logic [N-1:0][AW-1:0] RST_LENGTH = {64'h0, 64'h0, 64'h0, 64'h4000_0000};
  localparam logic [N-1:0][3:0]    RST_ATTR   = {4'h0, 4'h0, 4'h0, 4'b0011};
  localparam logic [3:0]           DEF_ATTR   = 4'b1000;

  logic          clk, rst_n;
  logic          cfg_req, cfg_we;
  logic [1:0]    cfg_idx, cfg_field;
  logic [AW-1:0] cfg_wdata, cfg_rdata, lkp_addr;
  logic          cfg_rvalid, cfg_err;
  logic          lkp_valid, lkp_ready, rsp_valid, rsp_ready, rsp_hit;
  logic [1:0]    rsp_idx;
  logic [3:0]    rsp_attr;

  region_attr_unit #(
    .NrRules(N), .AddrWidth(AW), .RstBase(RST_BASE), .RstLength(RST_LENGTH),
    .RstAttr(RST_ATTR), .DefaultAttr(DEF_ATTR)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_field_i(cfg_field),
    .cfg_wdata_i(cfg_wdata), .cfg_rvalid_o(cfg_rvalid), .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
    .lkp_valid_i(lkp_valid), .lkp_ready_o(lkp_ready), .lkp_addr_i(lkp_addr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_hit_o(rsp_hit),
    .rsp_idx_o(rsp_idx), .rsp_attr_o(rsp_attr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [AW-1:0] m_base [N];
  logic [AW-1:0] m_len  [N];
  logic [3:0]    m_attr [N];
  logic          m_lock [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_base[i] = RST_BASE[i];
      m_len[i]  = RST_LENGTH[i];
      m_attr[i] = RST_ATTR[i];
      m_lock[i] = 1'b0;
    end
  endtask

  // Region is the half-open range [base, base+len) computed without wrap; first rule wins.
  function automatic logic [6:0] model_lookup(input logic [AW-1:0] a);
    logic [AW:0] region_end;
    for (int i = 0; i < N; i++) begin
      region_end = {1'b0, m_base[i]} + {1'b0, m_len[i]};
      if (m_len[i] != 0 && a >= m_base[i] && {1'b0, a} < region_end)
        return {1'b1, 2'(i), m_attr[i]};
    end
    return {1'b0, 2'b00, DEF_ATTR};
  endfunction

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];
  logic       prev_stall;
  logic [6:0] prev_rsp;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
        check("rsp_hold_data", 64'({rsp_hit, rsp_idx, rsp_attr}), 64'(prev_rsp));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected: got 0x%0h expected no response", {rsp_hit, rsp_idx, rsp_attr});
        end else begin
          check("rsp_data", 64'({rsp_hit, rsp_idx, rsp_attr}), 64'(exp_q.pop_front()));
        end
      end
      prev_stall <= rsp_valid && !rsp_ready;
      prev_rsp   <= {rsp_hit, rsp_idx, rsp_attr};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs();
    check("rst_cfg_rvalid", 64'(cfg_rvalid), 64'd0);
    check("rst_cfg_rdata", cfg_rdata, 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_fields", 64'({rsp_hit, rsp_idx, rsp_attr}), 64'd0);
    check("rst_lkp_ready", 64'(lkp_ready), 64'd1);
  endtask

  // Called #1 after a rising edge; reset is asserted immediately, discarding in-flight lookups.
  task automatic do_reset();
    lkp_valid = 1'b0;
    cfg_req   = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  task automatic cfg_access(input bit we, input int idx, input int field, input logic [63:0] wdata,
                            output logic [63:0] rdata, output logic err);
    @(posedge clk); #1;
    cfg_req = 1'b1; cfg_we = we; cfg_idx = 2'(idx); cfg_field = 2'(field); cfg_wdata = wdata;
    @(posedge clk); #1;
    cfg_req = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    check("cfg_rvalid", 64'(cfg_rvalid), 64'd1);
    rdata = cfg_rdata;
    err   = cfg_err;
    @(negedge clk);
    check("cfg_rvalid_pulse", 64'(cfg_rvalid), 64'd0);
  endtask

  task automatic cfg_write(input int idx, input int field, input logic [63:0] wdata);
    logic [63:0] rd;
    logic        err, exp_err;
    exp_err = m_lock[idx] || (field == 3);
    cfg_access(1'b1, idx, field, wdata, rd, err);
    check("cfg_write_err", 64'(err), 64'(exp_err));
    if (!exp_err) begin
      case (field)
        0: m_base[idx] = wdata;
        1: m_len[idx]  = wdata;
        2: begin m_attr[idx] = wdata[3:0]; m_lock[idx] = wdata[4]; end
        default: ;
      endcase
    end
  endtask

  task automatic cfg_read(input int idx, input int field);
    logic [63:0] rd, exp_rd;
    logic        err;
    case (field)
      0: exp_rd = m_base[idx];
      1: exp_rd = m_len[idx];
      2: exp_rd = 64'({m_lock[idx], m_attr[idx]});
      default: exp_rd = 64'd0;
    endcase
    cfg_access(1'b0, idx, field, 64'd0, rd, err);
    check("cfg_read_data", rd, exp_rd);
    check("cfg_read_err", 64'(err), 64'(field == 3));
  endtask

  task automatic lkp_send(input logic [63:0] a, input logic [6:0] e);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    lkp_valid = 1'b1;
    lkp_addr  = a;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (lkp_ready) begin
        got = 1'b1;
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    lkp_valid = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL lkp_accept_timeout: got ready=0 expected ready=1 within 20 cycles");
    end
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [63:0] addr;
    logic        hit;
    logic [1:0]  idx;
    logic [3:0]  attr;
  } vec_t;

  vec_t        tab_a [7];
  vec_t        tab_b [6];
  logic [63:0] bp_addrs [4];
  int          accepts, a_idx;

  initial begin
    tab_a = '{
      '{64'h1800, 1'b1, 2'd0, 4'b0100},
      '{64'h2000, 1'b1, 2'd1, 4'b0010},
      '{64'h1000, 1'b1, 2'd0, 4'b0100},
      '{64'h0FFF, 1'b1, 2'd1, 4'b0010},
      '{64'h1_0000, 1'b0, 2'd0, DEF_ATTR},
      '{64'h1FFF, 1'b1, 2'd0, 4'b0100},
      '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'd3, 4'b0001}
    };
    tab_b = '{
      '{64'h0, 1'b0, 2'd0, DEF_ATTR},
      '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'd3, 4'b0001},
      '{64'hFFFF_FFFF_FFFF_F000, 1'b1, 2'd3, 4'b0001},
      '{64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 2'd0, DEF_ATTR},
      '{64'h1800, 1'b1, 2'd0, 4'b0100},
      '{64'h2000, 1'b0, 2'd0, DEF_ATTR}
    };
    bp_addrs = '{64'h1800, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF0, 64'h1000};

    rst_n = 1'b0; cfg_req = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_field = '0;
    cfg_wdata = '0; lkp_valid = 1'b0; lkp_addr = '0; rsp_ready = 1'b1;
    model_reset();
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset rule and two-cycle latency.
    @(posedge clk); #1;
    lkp_valid = 1'b1; lkp_addr = 64'h8000_1000;
    exp_q.push_back({1'b1, 2'd0, 4'b0011});
    @(negedge clk);
    check("lat_ready_t", 64'(lkp_ready), 64'd1);
    check("lat_valid_t", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    lkp_valid = 1'b0;
    @(negedge clk);
    check("lat_valid_t1", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("lat_valid_t2", 64'(rsp_valid), 64'd1);
    drain();

    // Lock behaviour, reserved field, and lock clearing by reset.
    cfg_write(2, 2, 64'h1F);
    cfg_write(2, 0, 64'h1234);
    cfg_read(2, 0);
    cfg_read(2, 2);
    cfg_read(2, 3);
    cfg_write(1, 3, 64'h55);
    @(posedge clk); #1;
    do_reset();
    cfg_read(2, 2);
    cfg_read(0, 0);

    // Reset with a lookup in flight: no response may appear.
    @(posedge clk); #1;
    lkp_valid = 1'b1; lkp_addr = 64'h8000_0000;
    @(posedge clk); #1;
    do_reset();
    repeat (3) begin
      @(negedge clk);
      check("rst_midop_no_rsp", 64'(rsp_valid), 64'd0);
    end

    // Overlap priority and top-of-space boundary tables.
    cfg_write(0, 0, 64'h1000); cfg_write(0, 1, 64'h1000); cfg_write(0, 2, 64'h4);
    cfg_write(1, 0, 64'h0);    cfg_write(1, 1, 64'h1_0000); cfg_write(1, 2, 64'h2);
    cfg_write(3, 0, 64'hFFFF_FFFF_FFFF_F000); cfg_write(3, 1, 64'h2000); cfg_write(3, 2, 64'h1);
    foreach (tab_a[i]) lkp_send(tab_a[i].addr, {tab_a[i].hit, tab_a[i].idx, tab_a[i].attr});
    drain();
    cfg_write(1, 1, 64'h0);
    foreach (tab_b[i]) lkp_send(tab_b[i].addr, {tab_b[i].hit, tab_b[i].idx, tab_b[i].attr});
    drain();

    // Backpressure: five request cycles with the response side stalled.
    rsp_ready = 1'b0;
    accepts = 0;
    a_idx = 0;
    @(posedge clk); #1;
    lkp_valid = 1'b1; lkp_addr = bp_addrs[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (lkp_ready) begin
        exp_q.push_back(model_lookup(lkp_addr));
        accepts++;
        a_idx++;
      end
      @(posedge clk); #1;
      lkp_addr = bp_addrs[a_idx];
    end
    check("bp_accepts", 64'(accepts), 64'd2);
    @(negedge clk);
    check("bp_ready_low", 64'(lkp_ready), 64'd0);
    @(posedge clk); #1;
    lkp_valid = 1'b0;
    drain();

    // Length write and lookup in the same cycle, then a lookup one cycle later.
    cfg_write(0, 1, 64'h0);
    cfg_write(1, 1, 64'h1_0000);
    @(posedge clk); #1;
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd1; cfg_field = 2'd1; cfg_wdata = 64'h0;
    lkp_valid = 1'b1; lkp_addr = 64'h2000;
    @(negedge clk);
    check("same_cycle_ready", 64'(lkp_ready), 64'd1);
    exp_q.push_back({1'b1, 2'd1, 4'b0010});
    @(posedge clk); #1;
    cfg_req = 1'b0; cfg_we = 1'b0;
    m_len[1] = 64'h0;
    @(negedge clk);
    check("same_cycle_cfg_err", 64'({cfg_rvalid, cfg_err}), 64'b10);
    exp_q.push_back(model_lookup(64'h2000));
    @(posedge clk); #1;
    lkp_valid = 1'b0;
    drain();

    // Attribute write in the acceptance cycle is seen by the response.
    cfg_write(1, 1, 64'h1_0000);
    @(posedge clk); #1;
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd1; cfg_field = 2'd2; cfg_wdata = 64'h9;
    lkp_valid = 1'b1; lkp_addr = 64'h3000;
    exp_q.push_back({1'b1, 2'd1, 4'h9});
    @(posedge clk); #1;
    cfg_req = 1'b0; cfg_we = 1'b0; lkp_valid = 1'b0;
    m_attr[1] = 4'h9;
    drain();

    // Randomized rules and lookups against the model.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) begin
        if (k == 2) continue;
        cfg_write(k, 0, 64'($urandom_range(0, 'h3000)));
        cfg_write(k, 1, ($urandom_range(0, 3) == 0) ? 64'h0 : 64'($urandom_range(1, 'h2000)));
        cfg_write(k, 2, 64'($urandom_range(0, 15)));
      end
      for (int c = 0; c < 150; c++) begin
        @(posedge clk); #1;
        rsp_ready = ($urandom_range(0, 3) != 0);
        lkp_valid = $urandom_range(0, 1);
        lkp_addr  = ($urandom_range(0, 15) == 0) ? {32'($urandom), 32'($urandom)}
                                                  : 64'($urandom_range(0, 'h5000));
        @(negedge clk);
        if (lkp_valid && lkp_ready) exp_q.push_back(model_lookup(lkp_addr));
      end
      @(posedge clk); #1;
      lkp_valid = 1'b0;
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/region_attr_unit.md
# region_attr_unit

Run-time programmable physical-memory attribute unit: the successor to the static cached, execute and non-idempotent region rules fixed at elaboration time. It holds `NrRules` base/length rules with per-rule attributes and sticky lock bits, initialised from parameters at reset. A two-stage, fully pipelined lookup port with valid/ready backpressure returns the attributes for a physical address. The unit sits beside the MMU/PMP path, and the fetch and LSU stages query it.

## Interface
- `NrRules`, 4: rule count, 1..16.
- `AddrWidth`, 64: address, base and length width.
- `RstBase`, all 0: `NrRules` x `AddrWidth` reset bases.
- `RstLength`, all 0: reset lengths; 0 disables the rule.
- `RstAttr`, all 0: `NrRules` x 4 reset attributes.
- `DefaultAttr`, 4'b0000: attributes returned on a miss.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `cfg_req_i` in 1: config access strobe.
- `cfg_we_i` in 1: 1 = write, 0 = read.
- `cfg_idx_i` in clog2(NrRules): rule index.
- `cfg_field_i` in 2: 0 = base, 1 = length, 2 = {lock, attr[3:0]}, 3 = reserved.
- `cfg_wdata_i` in AddrWidth: write data.
- `cfg_rvalid_o` out 1: read data or write status valid, one cycle after `cfg_req_i`.
- `cfg_rdata_o` out AddrWidth: read data, zero-extended.
- `cfg_err_o` out 1: write to a locked rule, reserved field, or out-of-range index.
- `lkp_valid_i` in 1: lookup request valid.
- `lkp_ready_o` out 1: lookup request ready.
- `lkp_addr_i` in AddrWidth: lookup address.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response ready.
- `rsp_hit_o` out 1: address matched a rule.
- `rsp_idx_o` out clog2(NrRules): matching rule index.
- `rsp_attr_o` out 4: attributes. Bit 0 cacheable, bit 1 executable, bit 2 non-idempotent, bit 3 capability-tag enable.

## Operation
- **Rule match.** Rule i matches when `length != 0`, `addr >= base`, and `(addr - base) < length`, all unsigned at `AddrWidth`. Because the `addr >= base` test gates the compare, a region running past the top of the address space never wraps to 0.
- **Priority.** The lowest matching index wins. On a miss: `rsp_hit_o`=0, `rsp_idx_o`=0, `rsp_attr_o`=`DefaultAttr`.
- **Config write.** Takes effect the cycle after `cfg_req_i`.
  - Write to field 2 sets the attributes and the lock bit.
  - Lock is sticky; only reset clears it.
  - While locked, writes to any field of that rule are dropped and `cfg_err_o`=1 with `cfg_rvalid_o`.
- **Config read.** Field 2 reads `{lock, attr}` in bits [4:0]. A reserved field or out-of-range index reads 0 with `cfg_err_o`=1 and no state change.
- **Lookup pipeline.**
  - S1 registers the raw match vector plus a valid bit.
  - S2 registers the priority-encoded hit, index and attributes plus a valid bit.
  - `lkp_ready_o` = !S1.valid || !S2.valid || `rsp_ready_i`.
  - S2 advances when it is empty or its response is consumed.
  - A stalled stage holds its contents unchanged.

## Timing
- **Reset values.** On reset, all rules take their `Rst*` values and all locks clear. Outputs at reset: `cfg_rvalid_o`=0, `cfg_rdata_o`=0, `cfg_err_o`=0, `rsp_valid_o`=0, `rsp_hit_o`=0, `rsp_idx_o`=0, `rsp_attr_o`=0, `lkp_ready_o`=1.
- **Lookup latency.** A lookup accepted in cycle t gives `rsp_valid_o` at t+2 with no backpressure. Throughput is 1 lookup per cycle.
- **Compare timing.** The compare in cycle t uses rule state as registered at t. A config write in cycle t is therefore invisible to a lookup accepted in t and visible to one accepted in t+1.
- **Attribute sampling.** S2 samples the attributes when S1 advances. An attribute write between acceptance and S2 load is visible in the response; base/length writes in that window are not.
- **Backpressure.** With `rsp_ready_i`=0 and both stages full, `lkp_ready_o`=0, and the response must stay stable until the handshake.
- **Config round trip.** `cfg_rvalid_o` is a one-cycle pulse at t+1. A config access may be issued every cycle.
- **Reset mid-operation.** In-flight lookups are discarded with no response. Config state returns to its reset values.

## Structure
- `region_attr_pkg` holds:
  - `attr_t`: packed struct of the four attribute bits.
  - `cfg_field_e` enum.
  - `rule_t` struct: base, length, attr, lock.
- Sub-module `region_attr_match`: combinational single-rule compare. It is instantiated `NrRules` times; the rule registers and the pipeline stay in the top level.

## Test plan
- **Reset rules.** `RstBase[0]`=0x8000_0000, `RstLength[0]`=0x4000_0000, `RstAttr[0]`=4'b0011; lookup 0x8000_1000 -> at t+2 hit=1, idx=0, attr=4'b0011.
- **Overlap priority.** Rule 0 = 0x1000/0x1000 attr 4'b0100, rule 1 = 0x0/0x10000 attr 4'b0010; lookup 0x1800 -> idx=0. Lookup 0x2000 -> idx=1. Lookup 0x10000 -> miss, `DefaultAttr`.
- **Lock.** Write field 2 = 0x1F to rule 2, then write base -> `cfg_err_o`=1 and readback is unchanged. Reset -> lock=0.
- **Top-of-space boundary.** Base 0xFFFF_FFFF_FFFF_F000, length 0x2000 -> 0xFFFF_FFFF_FFFF_FFFF hits, 0x0 misses.
- **Backpressure.** Back-to-back lookups with `rsp_ready_i`=0 for 5 cycles -> `lkp_ready_o` drops after 2 accepts. Responses arrive in order with no loss or duplication.
- **Write/lookup same cycle.** Length written to 0 in cycle t while a lookup is accepted in t -> hit. A lookup accepted in t+1 -> miss.
